// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: hazard/jump requests in, stall vector, redirect and counters out.
interface pipe_ctrl_if #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 32
);
    logic               rdy_in;
    logic               if_stallReq_in;
    logic               id_stallReq_in;
    logic               mem_stallReq_in;
    logic               ex_jump_in;
    logic [31:0]        ex_jumpTarget_in;
    logic               if_idle_in;
    logic [STALL_W-1:0] stall_out;
    logic               pcJump_out;
    logic               redirect_out;
    logic [31:0]        redirectAddr_out;
    logic [CNT_W-1:0]   stallCycles_out;
    logic [CNT_W-1:0]   flushCount_out;

    modport master (
        output rdy_in, if_stallReq_in, id_stallReq_in, mem_stallReq_in,
               ex_jump_in, ex_jumpTarget_in, if_idle_in,
        input  stall_out, pcJump_out, redirect_out, redirectAddr_out,
               stallCycles_out, flushCount_out
    );

    modport slave (
        input  rdy_in, if_stallReq_in, id_stallReq_in, mem_stallReq_in,
               ex_jump_in, ex_jumpTarget_in, if_idle_in,
        output stall_out, pcJump_out, redirect_out, redirectAddr_out,
               stallCycles_out, flushCount_out
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall control with jump flush, deferred PC redirect and perf counters.
module pipe_ctrl #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 32
) (
    input logic        clk_in,
    input logic        rst_in,
    pipe_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [STALL_W-1:0] STALL_MEM   = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] STALL_ID    = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_IF    = STALL_W'(6'b000011);
    localparam logic [STALL_W-1:0] STALL_FETCH = STALL_W'(2'b11);

    state_t             state_q, state_d;
    logic [31:0]        pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
    logic               accept_c;
    logic [STALL_W-1:0] stall_c;
    logic               pc_jump_c;
    logic               redirect_c;
    logic [31:0]        redirect_addr_c;

    // A jump stays parked in EX while memory is busy.
    assign accept_c = bus.rdy_in & bus.ex_jump_in & ~bus.mem_stallReq_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            IDLE: begin
                if (accept_c && !bus.if_idle_in) begin
                    state_d     = PENDING;
                    pend_addr_d = bus.ex_jumpTarget_in;
                end
            end
            PENDING: begin
                if (accept_c)
                    pend_addr_d = bus.ex_jumpTarget_in;
                if (bus.rdy_in && bus.if_idle_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (bus.mem_stallReq_in)     stall_c = STALL_MEM;
        else if (bus.id_stallReq_in) stall_c = STALL_ID;
        else if (bus.if_stallReq_in) stall_c = STALL_IF;
        else                         stall_c = '0;
        pc_jump_c       = accept_c;
        redirect_c      = 1'b0;
        redirect_addr_c = '0;
        case (state_q)
            IDLE: begin
                if (accept_c && bus.if_idle_in) begin
                    redirect_c      = 1'b1;
                    redirect_addr_c = bus.ex_jumpTarget_in;
                end
            end
            PENDING: begin
                // Hold PC and IF_ID so nothing fetched down the wrong path is latched.
                stall_c = stall_c | STALL_FETCH;
                if (bus.rdy_in && bus.if_idle_in) begin
                    redirect_c      = 1'b1;
                    redirect_addr_c = accept_c ? bus.ex_jumpTarget_in : pend_addr_q;
                end
            end
            default: ;
        endcase
        if (!bus.rdy_in) begin
            stall_c         = '1;
            pc_jump_c       = 1'b0;
            redirect_c      = 1'b0;
            redirect_addr_c = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) pend_addr_q <= '0;
        else         pend_addr_q <= pend_addr_d;
    end

    // Saturating performance counters; frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.rdy_in) begin
            if ((stall_c != '0) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (accept_c && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_out        = stall_c;
    assign bus.pcJump_out       = pc_jump_c;
    assign bus.redirect_out     = redirect_c;
    assign bus.redirectAddr_out = redirect_addr_c;
    assign bus.stallCycles_out  = stall_cnt_q;
    assign bus.flushCount_out   = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_W, default 6, stall vector width; bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 WB.
REQ-002 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-003 SHALL have port clk_in  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-006 SHALL have port if_stallReq_in  input  1  fetch not done this cycle.
REQ-007 SHALL have port id_stallReq_in  input  1  load-use hazard in ID.
REQ-008 SHALL have port mem_stallReq_in  input  1  memory access in progress.
REQ-009 SHALL have port ex_jump_in  input  1  EX resolved mispredict/jump.
REQ-010 SHALL have port ex_jumpTarget_in  input  32  redirect address.
REQ-011 SHALL have port if_idle_in  input  1  fetch unit can accept a new PC.
REQ-012 SHALL have port stall_out  output  STALL_W  stall vector to PC and pipeline registers.
REQ-013 SHALL have port pcJump_out  output  1  flush pulse to IF_ID and ID_EX.
REQ-014 SHALL have port redirect_out  output  1  redirect valid to PC register.
REQ-015 SHALL have port redirectAddr_out  output  32  redirect target.
REQ-016 SHALL have port stallCycles_out  output  CNT_W  cycles with stall_out nonzero.
REQ-017 SHALL have port flushCount_out  output  CNT_W  number of accepted jumps.

Function
REQ-018 stall_out SHALL be combinational, priority: mem_stallReq_in -> 6'b011111; else id_stallReq_in -> 6'b000111; else if_stallReq_in -> 6'b000011; else 6'b000000.
REQ-019 rdy_in low SHALL force stall_out = 6'b111111, pcJump_out = 0, redirect_out = 0, and hold all registers.
REQ-020 A jump SHALL be accepted in a cycle when ex_jump_in = 1, mem_stallReq_in = 0 and rdy_in = 1; EX holds the request while mem-stalled.
REQ-021 pcJump_out SHALL be asserted combinationally in exactly the cycle a jump is accepted; it SHALL take precedence over id/if stall at the pipeline registers.
REQ-022 FSM states IDLE and PENDING; reset state IDLE.
REQ-023 IDLE: accepted jump with if_idle_in = 1 -> redirect_out = 1 same cycle with redirectAddr_out = ex_jumpTarget_in, stay IDLE.
REQ-024 IDLE: accepted jump with if_idle_in = 0 -> latch target into pendAddr register, go PENDING next cycle.
REQ-025 PENDING: redirectAddr_out = pendAddr; redirect_out = if_idle_in; on if_idle_in = 1 go IDLE next cycle.
REQ-026 PENDING: a new accepted jump SHALL overwrite pendAddr (newest target wins), stay PENDING unless if_idle_in = 1 that cycle, in which case the new target is driven directly and FSM goes IDLE.
REQ-027 PENDING: stall_out bits 0 and 1 SHALL be forced to 1 so no wrong-path fetch is latched.
REQ-028 When not redirecting, redirect_out = 0 and redirectAddr_out = 0.
REQ-029 stallCycles_out SHALL increment by 1 each rdy_in = 1 cycle with stall_out nonzero; saturates at all-ones.
REQ-030 flushCount_out SHALL increment by 1 per accepted jump; saturates at all-ones; no wrap-around.

Reset
REQ-031 rst_in low SHALL asynchronously set FSM = IDLE, pendAddr = 0, both counters = 0; outputs follow REQ-018/028 with registers cleared.
REQ-032 Reset asserted while PENDING SHALL discard the pending target; no redirect after release.
REQ-033 On reset release, first rising edge SHALL behave as normal operation.

Verification
REQ-034 mem_stallReq_in = 1, id_stallReq_in = 1 -> stall_out = 6'b011111, stallCycles_out +1 per cycle.
REQ-035 id_stallReq_in = 1 only for 1 cycle -> stall_out = 6'b000111 that cycle, 6'b000000 next.
REQ-036 ex_jump_in = 1, target 0x0000_1000, if_idle_in = 1 -> pcJump_out = 1, redirect_out = 1, redirectAddr_out = 0x1000 same cycle, flushCount_out = 1 next.
REQ-037 jump 0x2000 with if_idle_in = 0 for 3 cycles, then 1 -> PENDING, stall_out[1:0] = 2'b11 for 3 cycles, redirect of 0x2000 in cycle 4, IDLE after.
REQ-038 ex_jump_in = 1 with mem_stallReq_in = 1 -> pcJump_out = 0, flushCount_out unchanged; accepted when mem stall drops.
REQ-039 rst_in low mid-PENDING -> counters 0, FSM IDLE, redirect_out = 0 after release with if_idle_in = 1.
